// File: rtl/mux16_rr_if.sv
// Requester-bank / scheduler bundle for the shared 16:1 mux.
// With MUX16_LOCK_EN defined, a lock input is added that pins the current grant.
interface mux16_rr_if;
  logic [15:0] req;
  logic [15:0] din;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        grant_valid;
  logic        dout;
  logic        dout_valid;
  logic [3:0]  dout_ch;
`ifdef MUX16_LOCK_EN
  logic        lock;

  modport master (output req, din, lock,
                  input  sel, grant, grant_valid, dout, dout_valid, dout_ch);
  modport slave  (input  req, din, lock,
                  output sel, grant, grant_valid, dout, dout_valid, dout_ch);
`else
  modport master (output req, din,
                  input  sel, grant, grant_valid, dout, dout_valid, dout_ch);
  modport slave  (input  req, din,
                  output sel, grant, grant_valid, dout, dout_valid, dout_ch);
`endif
endinterface

// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner of one 16:1 single-bit mux, with a registered, qualified data sample.
// Optional MUX16_LOCK_EN: lock input suppresses the hold-limit forced release.
//
// state | meaning
// IDLE  | no grant; next edge with any req picks the winner at/after ptr
// GRANT | grant = 1<<sel; released on req drop or hold limit with others waiting
module mux16_rr_scheduler #(
  parameter int MAX_HOLD  = 8,
  parameter int PTR_RESET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  mux16_rr_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_nxt;
  logic [3:0]  sel_q, sel_nxt;
  logic [3:0]  ptr_q, ptr_nxt;
  logic [7:0]  hold_q, hold_nxt;
  logic        dout_q, dv_q;
  logic [3:0]  dch_q;
  logic [3:0]  winner, idx;
  logic        found;
  logic        gv;
  logic [15:0] grant;
  logic        lock_ok;

`ifdef MUX16_LOCK_EN
  assign lock_ok = ~bus.lock;
`else
  assign lock_ok = 1'b1;
`endif

  assign gv    = (state_q == GRANT);
  assign grant = gv ? (16'h0001 << sel_q) : 16'h0000;

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    winner = 4'd0;
    found  = 1'b0;
    idx    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr_q;
    hold_nxt  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          hold_nxt  = 8'd0;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] ||
            (lock_ok && hold_q == HOLD_LAST && (bus.req & ~grant) != 16'h0000)) begin
          state_nxt = IDLE;
          ptr_nxt   = sel_q + 4'd1;
          hold_nxt  = 8'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_nxt = hold_q + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      ptr_q   <= 4'(PTR_RESET);
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      ptr_q   <= ptr_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // Sample follows the pre-edge select, so dout trails grant_valid by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      dv_q   <= 1'b0;
      dch_q  <= 4'd0;
    end else begin
      dout_q <= bus.din[sel_q];
      dv_q   <= gv;
      dch_q  <= sel_q;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.grant       = grant;
  assign bus.grant_valid = gv;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dv_q;
  assign bus.dout_ch     = dch_q;

endmodule
